// File: rtl/bp_be_fe_cmd_issuer_if.sv
// Request/command bus between the BE request sources and the FE command queue.
// The issuer takes the slave side; whoever raises requests and consumes fe_cmd takes the master side.
interface bp_be_fe_cmd_issuer_if #(
    parameter int vaddr_width_p               = 39,
    parameter int branch_metadata_fwd_width_p = 36,
    parameter int tlb_entry_width_p           = 52,
    parameter int fe_cmd_width_p              = 94
);
    logic [vaddr_width_p-1:0]               boot_pc_i;
    logic                                   redirect_v_i;
    logic [vaddr_width_p-1:0]               redirect_pc_i;
    logic                                   redirect_trap_i;
    logic [1:0]                             redirect_priv_i;
    logic                                   redirect_translation_en_i;
    logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_i;
    logic                                   attaboy_v_i;
    logic [vaddr_width_p-1:0]               attaboy_pc_i;
    logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_i;
    logic                                   icache_fence_v_i;
    logic                                   itlb_fence_v_i;
    logic                                   itlb_fill_v_i;
    logic [vaddr_width_p-1:0]               itlb_fill_vaddr_i;
    logic [tlb_entry_width_p-1:0]           itlb_fill_entry_i;
    logic                                   req_ready_o;
    logic [fe_cmd_width_p-1:0]              fe_cmd_o;
    logic                                   fe_cmd_v_o;
    logic                                   fe_cmd_yumi_i;
    logic                                   cmd_pending_o;
    logic                                   attaboy_drop_o;

    modport slave (
        input  boot_pc_i, redirect_v_i, redirect_pc_i, redirect_trap_i, redirect_priv_i,
               redirect_translation_en_i, redirect_br_metadata_i, attaboy_v_i, attaboy_pc_i,
               attaboy_br_metadata_i, icache_fence_v_i, itlb_fence_v_i, itlb_fill_v_i,
               itlb_fill_vaddr_i, itlb_fill_entry_i, fe_cmd_yumi_i,
        output req_ready_o, fe_cmd_o, fe_cmd_v_o, cmd_pending_o, attaboy_drop_o
    );

    modport master (
        output boot_pc_i, redirect_v_i, redirect_pc_i, redirect_trap_i, redirect_priv_i,
               redirect_translation_en_i, redirect_br_metadata_i, attaboy_v_i, attaboy_pc_i,
               attaboy_br_metadata_i, icache_fence_v_i, itlb_fence_v_i, itlb_fill_v_i,
               itlb_fill_vaddr_i, itlb_fill_entry_i, fe_cmd_yumi_i,
        input  req_ready_o, fe_cmd_o, fe_cmd_v_o, cmd_pending_o, attaboy_drop_o
    );
endinterface

// File: rtl/bp_be_fe_cmd_issuer.sv
// Encodes BE requests into FE commands and queues them in a small FIFO.
// fe_cmd layout (LSB first): opcode[2:0], vaddr, operands {br_metadata, translation_en, priv[1:0], subop[2:0]}.
module bp_be_fe_cmd_issuer #(
    parameter int bp_params_p = 0,  // 0 = e_bp_inv_cfg
    parameter int cmd_els_p   = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    bp_be_fe_cmd_issuer_if.slave   io
);
    // state   | meaning
    // e_boot  | first cycle out of reset: push the state_reset command
    // e_run   | accept BE requests by fixed priority

    localparam int vaddr_width_p               = (bp_params_p == 0) ? 39 : 48;
    localparam int paddr_width_p               = (bp_params_p == 0) ? 56 : 64;
    localparam int branch_metadata_fwd_width_p = 36;
    localparam int tlb_entry_width_p           = paddr_width_p - 12 + 8;  // ptag + permission bits
    localparam int MetaLsb                     = 6;
    localparam int op_width_lp = (MetaLsb + branch_metadata_fwd_width_p > tlb_entry_width_p)
                               ? (MetaLsb + branch_metadata_fwd_width_p) : tlb_entry_width_p;
    localparam int fe_cmd_width_lp             = op_width_lp + vaddr_width_p + 3;
    localparam int LgEls                       = $clog2(cmd_els_p);
    localparam logic [LgEls:0] OccMax          = (LgEls+1)'(cmd_els_p);
    localparam logic [LgEls:0] OccAbMax        = (LgEls+1)'(cmd_els_p - 2);

    typedef enum logic [2:0] {
        e_op_state_reset        = 3'd0,
        e_op_pc_redirection     = 3'd1,
        e_op_icache_fence       = 3'd2,
        e_op_attaboy            = 3'd3,
        e_op_itlb_fill_response = 3'd4,
        e_op_itlb_fence         = 3'd5
    } fe_cmd_opcode_e;

    typedef enum logic [2:0] {
        e_subop_none              = 3'd0,
        e_subop_branch_mispredict = 3'd1,
        e_subop_trap              = 3'd2
    } fe_cmd_subop_e;

    typedef enum logic {e_boot, e_run} state_e;

    state_e                     state_q, state_d;
    logic [fe_cmd_width_lp-1:0] mem_q [cmd_els_p];
    logic [LgEls-1:0]           wptr_q, rptr_q;
    logic [LgEls:0]             occ_q, occ_d;
    logic [LgEls:0]             pend_q, pend_d;

    logic                       enq_v, enq_ab, deq, head_ab;
    fe_cmd_opcode_e             enq_opcode;
    logic [vaddr_width_p-1:0]   enq_vaddr;
    logic [op_width_lp-1:0]     enq_operands;
    logic [fe_cmd_width_lp-1:0] enq_cmd;
    logic                       req_ready, attaboy_drop;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_boot;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            e_boot: state_d = e_run;
            e_run:  state_d = e_run;
        endcase
    end

    always_comb begin
        enq_v        = 1'b0;
        enq_ab       = 1'b0;
        enq_opcode   = e_op_state_reset;
        enq_vaddr    = '0;
        enq_operands = '0;
        req_ready    = 1'b0;
        attaboy_drop = 1'b0;
        if (!reset_i) begin
            unique case (state_q)
                e_boot: begin
                    enq_v             = 1'b1;
                    enq_vaddr         = io.boot_pc_i;
                    enq_operands[4:3] = 2'b11;
                end
                e_run: begin
                    req_ready = (occ_q < OccMax);
                    if (io.redirect_v_i) begin
                        enq_v      = req_ready;
                        enq_opcode = e_op_pc_redirection;
                        enq_vaddr  = io.redirect_pc_i;
                        if (io.redirect_trap_i) begin
                            enq_operands[2:0] = e_subop_trap;
                            enq_operands[4:3] = io.redirect_priv_i;
                            enq_operands[5]   = io.redirect_translation_en_i;
                        end else begin
                            enq_operands[2:0] = e_subop_branch_mispredict;
                            enq_operands[MetaLsb +: branch_metadata_fwd_width_p] = io.redirect_br_metadata_i;
                        end
                    end else if (io.itlb_fill_v_i) begin
                        enq_v      = req_ready;
                        enq_opcode = e_op_itlb_fill_response;
                        enq_vaddr  = io.itlb_fill_vaddr_i;
                        enq_operands[tlb_entry_width_p-1:0] = io.itlb_fill_entry_i;
                    end else if (io.itlb_fence_v_i) begin
                        enq_v      = req_ready;
                        enq_opcode = e_op_itlb_fence;
                    end else if (io.icache_fence_v_i) begin
                        enq_v      = req_ready;
                        enq_opcode = e_op_icache_fence;
                    end else if (io.attaboy_v_i) begin
                        // keep one slot in reserve so a redirect can always land
                        if (occ_q <= OccAbMax) begin
                            enq_v      = 1'b1;
                            enq_ab     = 1'b1;
                            enq_opcode = e_op_attaboy;
                            enq_vaddr  = io.attaboy_pc_i;
                            enq_operands[MetaLsb +: branch_metadata_fwd_width_p] = io.attaboy_br_metadata_i;
                        end else begin
                            attaboy_drop = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign enq_cmd = {enq_operands, enq_vaddr, enq_opcode};
    assign deq     = io.fe_cmd_yumi_i & io.fe_cmd_v_o;
    assign head_ab = (mem_q[rptr_q][2:0] == e_op_attaboy);

    always_comb begin
        occ_d  = occ_q;
        pend_d = pend_q;
        if (enq_v && !deq) begin
            occ_d = occ_q + (LgEls+1)'(1);
        end else if (!enq_v && deq) begin
            occ_d = occ_q - (LgEls+1)'(1);
        end
        if ((enq_v && !enq_ab) && !(deq && !head_ab)) begin
            pend_d = pend_q + (LgEls+1)'(1);
        end else if (!(enq_v && !enq_ab) && (deq && !head_ab)) begin
            pend_d = pend_q - (LgEls+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            pend_q <= '0;
        end else begin
            if (enq_v) begin
                wptr_q <= wptr_q + LgEls'(1);
            end
            if (deq) begin
                rptr_q <= rptr_q + LgEls'(1);
            end
            occ_q  <= occ_d;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_v) begin
            mem_q[wptr_q] <= enq_cmd;
        end
    end

    assign io.fe_cmd_o       = mem_q[rptr_q];
    assign io.fe_cmd_v_o     = !reset_i && (occ_q != '0);
    assign io.cmd_pending_o  = !reset_i && (pend_q != '0);
    assign io.req_ready_o    = req_ready;
    assign io.attaboy_drop_o = attaboy_drop;
endmodule

// File: tb/tb_bp_be_fe_cmd_issuer.sv
// Directed scenarios followed by a randomized run, all checked against a queue-based command model.
module tb_bp_be_fe_cmd_issuer;
    localparam int VW  = 39;
    localparam int MW  = 36;
    localparam int EW  = 52;
    localparam int OPW = 52;
    localparam int CW  = 94;
    localparam int N   = 4;

    localparam logic [2:0] OP_RESET = 3'd0, OP_REDIR = 3'd1, OP_ICF = 3'd2,
                           OP_AB = 3'd3, OP_FILL = 3'd4, OP_ITF = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_be_fe_cmd_issuer_if #(
        .vaddr_width_p(VW), .branch_metadata_fwd_width_p(MW),
        .tlb_entry_width_p(EW), .fe_cmd_width_p(CW)
    ) bus ();

    bp_be_fe_cmd_issuer #(.bp_params_p(0), .cmd_els_p(N)) dut (
        .clk_i(clk), .reset_i(rst), .io(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [CW-1:0] mq[$];
    bit            mab[$];
    bit            booted = 1'b0;

    function automatic logic [CW-1:0] mk(input logic [2:0] op, input logic [VW-1:0] va,
                                          input logic [OPW-1:0] opnd);
        return {opnd, va, op};
    endfunction

    function automatic int pending_cnt();
        int c = 0;
        foreach (mab[i]) if (!mab[i]) c++;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs against the model at the falling edge, then advance the model.
    task automatic cycle();
        logic          e_v, e_p, e_r, e_d, push, pab;
        logic [CW-1:0] pc;
        int            sz;
        @(negedge clk);
        sz = mq.size();
        e_v = 1'b0; e_p = 1'b0; e_r = 1'b0; e_d = 1'b0; push = 1'b0; pab = 1'b0; pc = '0;
        if (!rst) begin
            e_v = (sz != 0);
            e_p = (pending_cnt() != 0);
            if (!booted) begin
                push = 1'b1;
                pc   = mk(OP_RESET, bus.boot_pc_i, OPW'(3) << 3);
            end else begin
                e_r = (sz < N);
                if (bus.redirect_v_i) begin
                    push = e_r;
                    if (bus.redirect_trap_i)
                        pc = mk(OP_REDIR, bus.redirect_pc_i, OPW'(2) | (OPW'(bus.redirect_priv_i) << 3)
                                | (OPW'(bus.redirect_translation_en_i) << 5));
                    else
                        pc = mk(OP_REDIR, bus.redirect_pc_i, OPW'(1) | (OPW'(bus.redirect_br_metadata_i) << 6));
                end else if (bus.itlb_fill_v_i) begin
                    push = e_r;
                    pc   = mk(OP_FILL, bus.itlb_fill_vaddr_i, OPW'(bus.itlb_fill_entry_i));
                end else if (bus.itlb_fence_v_i) begin
                    push = e_r;
                    pc   = mk(OP_ITF, '0, '0);
                end else if (bus.icache_fence_v_i) begin
                    push = e_r;
                    pc   = mk(OP_ICF, '0, '0);
                end else if (bus.attaboy_v_i) begin
                    if (sz <= N - 2) begin
                        push = 1'b1;
                        pab  = 1'b1;
                        pc   = mk(OP_AB, bus.attaboy_pc_i, OPW'(bus.attaboy_br_metadata_i) << 6);
                    end else begin
                        e_d = 1'b1;
                    end
                end
            end
        end
        chk("fe_cmd_v", bus.fe_cmd_v_o, e_v);
        chk("req_ready", bus.req_ready_o, e_r);
        chk("cmd_pending", bus.cmd_pending_o, e_p);
        chk("attaboy_drop", bus.attaboy_drop_o, e_d);
        if (e_v) chk("fe_cmd_head", bus.fe_cmd_o, mq[0]);
        if (rst) begin
            mq.delete();
            mab.delete();
            booted = 1'b0;
        end else begin
            if (bus.fe_cmd_yumi_i && sz != 0) begin
                void'(mq.pop_front());
                void'(mab.pop_front());
            end
            if (push) begin
                mq.push_back(pc);
                mab.push_back(pab);
            end
            booted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.redirect_v_i     = 1'b0;
        bus.attaboy_v_i      = 1'b0;
        bus.icache_fence_v_i = 1'b0;
        bus.itlb_fence_v_i   = 1'b0;
        bus.itlb_fill_v_i    = 1'b0;
        bus.fe_cmd_yumi_i    = 1'b0;
    endtask

    task automatic rand_fields();
        bus.redirect_pc_i             = VW'({$urandom, $urandom});
        bus.redirect_trap_i           = 1'($urandom);
        bus.redirect_priv_i           = 2'($urandom);
        bus.redirect_translation_en_i = 1'($urandom);
        bus.redirect_br_metadata_i    = MW'({$urandom, $urandom});
        bus.attaboy_pc_i              = VW'({$urandom, $urandom});
        bus.attaboy_br_metadata_i     = MW'({$urandom, $urandom});
        bus.itlb_fill_vaddr_i         = VW'({$urandom, $urandom});
        bus.itlb_fill_entry_i         = EW'({$urandom, $urandom});
    endtask

    task automatic drain(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) begin
            bus.fe_cmd_yumi_i = (mq.size() != 0);
            cycle();
        end
        bus.fe_cmd_yumi_i = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rand_fields();
        bus.boot_pc_i = VW'(64'h8000_0000);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // boot command
        rst = 1'b0;
        cycle();
        #1;
        chk("boot_op", bus.fe_cmd_o[2:0], OP_RESET);
        chk("boot_vaddr", bus.fe_cmd_o[41:3], 39'h8000_0000);
        chk("boot_priv", bus.fe_cmd_o[46:45], 2'b11);
        chk("boot_pending", bus.cmd_pending_o, 1'b1);
        drain(2);
        chk("boot_drained_v", bus.fe_cmd_v_o, 1'b0);
        chk("boot_drained_pend", bus.cmd_pending_o, 1'b0);

        // fill with fences, fifth one held
        for (int i = 0; i < 5; i++) begin
            bus.itlb_fence_v_i   = i[0];
            bus.icache_fence_v_i = !i[0];
            cycle();
        end
        #1;
        chk("full_ready", bus.req_ready_o, 1'b0);
        drain(5);

        // attaboy dropped at occupancy 3, redirect still lands
        rand_fields();
        bus.redirect_v_i = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        bus.redirect_v_i = 1'b0;
        bus.attaboy_v_i  = 1'b1;
        #1;
        chk("ab_drop_at3", bus.attaboy_drop_o, 1'b1);
        cycle();
        bus.attaboy_v_i  = 1'b0;
        bus.redirect_v_i = 1'b1;
        #1;
        chk("redir_ready_at3", bus.req_ready_o, 1'b1);
        cycle();
        bus.redirect_v_i = 1'b0;
        #1;
        chk("ready_at4", bus.req_ready_o, 1'b0);
        drain(5);

        // same-cycle priority
        rand_fields();
        bus.redirect_v_i  = 1'b1;
        bus.itlb_fill_v_i = 1'b1;
        bus.attaboy_v_i   = 1'b1;
        cycle();
        idle_inputs();
        #1;
        chk("prio_op", bus.fe_cmd_o[2:0], OP_REDIR);
        drain(3);

        // full FIFO with yumi and redirect together
        bus.itlb_fill_v_i = 1'b1;
        for (int i = 0; i < 4; i++) begin rand_fields(); cycle(); end
        bus.itlb_fill_v_i = 1'b0;
        bus.redirect_v_i  = 1'b1;
        bus.fe_cmd_yumi_i = 1'b1;
        cycle();
        bus.fe_cmd_yumi_i = 1'b0;
        cycle();
        bus.redirect_v_i = 1'b0;
        drain(6);

        // reset with queued commands
        bus.icache_fence_v_i = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        bus.icache_fence_v_i = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) cycle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) cycle();
        chk("rst_only_boot_op", bus.fe_cmd_o[2:0], OP_RESET);
        drain(3);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            rand_fields();
            bus.redirect_v_i     = ($urandom_range(0, 5) == 0);
            bus.itlb_fill_v_i    = ($urandom_range(0, 7) == 0);
            bus.itlb_fence_v_i   = ($urandom_range(0, 9) == 0);
            bus.icache_fence_v_i = ($urandom_range(0, 9) == 0);
            bus.attaboy_v_i      = ($urandom_range(0, 1) == 0);
            if ((i / 64) % 2 == 0)
                bus.fe_cmd_yumi_i = (mq.size() != 0) && ($urandom_range(0, 3) == 0);
            else
                bus.fe_cmd_yumi_i = (mq.size() != 0) && ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst = 1'b0;
        drain(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
